icache_fetch_interface: RTL and testbench
=========================================

# icache_fetch_interface

Parametrised fetch-side front end between the fetch stage and the instruction memories (L1 ICache and bootrom). Supports up to `MAX_OUTSTANDING` in-flight requests with an in-order tracking FIFO, configurable line and instruction widths, kill of in-flight fetches without losing response alignment, and a registered response to fetch. Sits between the fetch stage and the ICache/bootrom ports.

## Interface
- `ADDR_WIDTH`, 40: virtual address width.
- `LINE_WIDTH`, 128: ICache response line width; power of two, ≥ `INSTR_WIDTH`.
- `INSTR_WIDTH`, 32: word returned to fetch.
- `MAX_OUTSTANDING`, 2: tracking FIFO depth, ≥1.
- `BROM_SIZE`, 'h100: addresses below this, with translation off and SPI config clear, go to bootrom.
- `BROM_ADDR_WIDTH`, 24: bootrom address width.
---
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; **one clock; reset is synchronous and active-high.**
- `req_valid_i` in 1 / `req_vaddr_i` in ADDR_WIDTH: fetch request.
- `req_kill_i` in 1: drop all in-flight fetches.
- `req_inval_icache_i` in 1: pass-through to `icache_invalidate_o`.
- `en_translation_i`, `csr_spi_config_i` in 1: bootrom decode qualifiers.
- `req_ready_o` out 1: request accepted this cycle when high with `req_valid_i`.
- `icache_req_valid_o` out 1, `icache_req_ready_i` in 1, `icache_req_idx_o` out 12 (vaddr[11:0]), `icache_req_vpn_o` out ADDR_WIDTH-12 (vaddr[ADDR_WIDTH-1:12]), `icache_req_kill_o` out 1, `icache_invalidate_o` out 1.
- `icache_resp_valid_i` in 1, `icache_resp_data_i` in LINE_WIDTH, `icache_resp_xcpt_i` in 1 (TLB instruction page fault; counts as a response).
- `brom_req_valid_o` out 1, `brom_req_ready_i` in 1, `brom_req_addr_o` out BROM_ADDR_WIDTH, `brom_resp_valid_i` in 1, `brom_resp_data_i` in INSTR_WIDTH.
- `resp_valid_o` out 1, `resp_data_o` out INSTR_WIDTH, `resp_vaddr_o` out ADDR_WIDTH, `resp_page_fault_o` out 1.
- `outstanding_o` out $clog2(MAX_OUTSTANDING+1): live FIFO occupancy.
- `spurious_resp_o` out 1: sticky; response arrived with FIFO empty.

## Operation
- Target decode: bootrom iff `~en_translation_i & vaddr < BROM_SIZE & ~csr_spi_config_i`; else ICache.
- FSM `IDLE` (FIFO empty), `IC_BUSY` (entries to ICache), `BR_BUSY` (entries to bootrom). IDLE→IC_BUSY/BR_BUSY on accept; back to IDLE when last entry pops with no accept the same cycle.
- Accept = `req_valid_i & target ready & ~full-after-pop & source ok`. Source ok: IDLE, or target equals current busy source. Different source stalls until FIFO drains (guarantees ordering).
- `req_ready_o` = accept condition excluding `req_valid_i`; `icache_req_valid_o`/`brom_req_valid_o` = accept steered to target.
- Push entry {vaddr, is_brom, drop=0}. Pop on matching-source response (ICache valid or xcpt; bootrom valid).
- Word select: `vaddr[$clog2(LINE_WIDTH/8)-1:$clog2(INSTR_WIDTH/8)]` of head entry; bootrom data passes whole. Xcpt: data 0, page_fault 1.
- Kill: set drop on every entry present; a request accepted in the kill cycle is not dropped. `icache_req_kill_o = req_kill_i`. Dropped pops produce no `resp_valid_o`.
- Response with FIFO empty or wrong source: ignored, `spurious_resp_o` set until reset.

## Timing
- Reset: FIFO empty, FSM IDLE, `resp_valid_o`=0, `resp_data_o`=0, `resp_vaddr_o`=0, `resp_page_fault_o`=0, `outstanding_o`=0, `spurious_resp_o`=0. Combinational request outputs follow inputs.
- Response: `resp_*` registered, valid exactly 1 cycle after the memory response; single-cycle pulse per response.
- Push and pop in the same cycle legal at full; occupancy unchanged.
- Kill coincident with a response: that response is dropped.
- Reset mid-operation clears all entries; later stale responses flag `spurious_resp_o`.

## Structure
- `drac_pkg`: `fetch_track_t` {vaddr, is_brom, drop}, `BROM_SIZE` default, `fetch_src_state_t` enum.
- Sub-module `fetch_track_fifo` (parametrised depth, push/pop, bulk drop-mark, count).

## Test plan
- ICache req vaddr 0x8000_0008, resp line {0xDDDD, 0xCCCC, 0xBBBB, 0xAAAA} next cycle -> resp_valid_o one cycle later, data 0xCCCC, vaddr 0x8000_0008.
- Two back-to-back requests 0x1000, 0x1004 (depth 2) -> third stalls (`req_ready_o`=0), responses returned in order, outstanding_o 2→0.
- Kill with 2 in flight, new req 0x2000 same cycle -> first two responses suppressed, 0x2000 response delivered.
- Bootrom req 0x40 while ICache entry pending -> stalled until drain, then `brom_req_addr_o`=0x40, data passes through.
- `icache_resp_xcpt_i` -> resp_data_o 0, resp_page_fault_o 1, entry popped.
- Reset with 1 in flight, then ICache response -> no resp_valid_o, spurious_resp_o=1.

Source files
------------

// File: rtl/icache_fetch_interface_pkg.sv
// Shared types for the fetch front end: tracking-FIFO entry, bootrom window default
// and fetch source encoding.
package drac_pkg;

  localparam int unsigned VADDR_MAX_W   = 64;
  localparam int unsigned BROM_SIZE_DEF = 'h100;

  typedef struct packed {
    logic [VADDR_MAX_W-1:0] vaddr;
    logic                   is_brom;
    logic                   drop;
  } fetch_track_t;

  typedef enum logic [1:0] {
    SRC_IDLE   = 2'd0,
    SRC_ICACHE = 2'd1,
    SRC_BROM   = 2'd2
  } fetch_src_state_t;

endpackage

// File: rtl/icache_fetch_interface_track_fifo.sv
// In-order tracker of in-flight fetches; head visible combinationally, push/pop take
// effect at the next edge, caller guarantees no push when full unless popping.
module fetch_track_fifo
  import drac_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  fetch_track_t                 push_dat_i,
  input  logic                         pop_i,
  input  logic                         drop_all_i,
  output fetch_track_t                 head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH-1);

  fetch_track_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (pop_i)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // The push write comes last so an entry accepted in a kill cycle keeps drop clear.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (drop_all_i) mem[i].drop <= 1'b1;
    end
    if (push_i) mem[wr_ptr] <= push_dat_i;
  end

  assign head_o  = mem[rd_ptr];
  assign count_o = count;

endmodule

// File: rtl/icache_fetch_interface.sv
// Fetch front end steering requests to ICache or bootrom with in-order tracking;
// response registered one cycle after the memory, requests stall on full FIFO or source switch.
module icache_fetch_interface
  import drac_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 40,
  parameter int unsigned LINE_WIDTH      = 128,
  parameter int unsigned INSTR_WIDTH     = 32,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned BROM_SIZE       = BROM_SIZE_DEF,
  parameter int unsigned BROM_ADDR_WIDTH = 24
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   req_valid_i,
  input  logic [ADDR_WIDTH-1:0]                  req_vaddr_i,
  input  logic                                   req_kill_i,
  input  logic                                   req_inval_icache_i,
  input  logic                                   en_translation_i,
  input  logic                                   csr_spi_config_i,
  output logic                                   req_ready_o,
  output logic                                   icache_req_valid_o,
  input  logic                                   icache_req_ready_i,
  output logic [11:0]                            icache_req_idx_o,
  output logic [ADDR_WIDTH-13:0]                 icache_req_vpn_o,
  output logic                                   icache_req_kill_o,
  output logic                                   icache_invalidate_o,
  input  logic                                   icache_resp_valid_i,
  input  logic [LINE_WIDTH-1:0]                  icache_resp_data_i,
  input  logic                                   icache_resp_xcpt_i,
  output logic                                   brom_req_valid_o,
  input  logic                                   brom_req_ready_i,
  output logic [BROM_ADDR_WIDTH-1:0]             brom_req_addr_o,
  input  logic                                   brom_resp_valid_i,
  input  logic [INSTR_WIDTH-1:0]                 brom_resp_data_i,
  output logic                                   resp_valid_o,
  output logic [INSTR_WIDTH-1:0]                 resp_data_o,
  output logic [ADDR_WIDTH-1:0]                  resp_vaddr_o,
  output logic                                   resp_page_fault_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   spurious_resp_o
);

  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING+1);
  localparam int unsigned WORDS  = LINE_WIDTH / INSTR_WIDTH;
  localparam int unsigned OFF_LO = $clog2(INSTR_WIDTH/8);
  localparam int unsigned IW_LOG = $clog2(INSTR_WIDTH);
  localparam int unsigned SEL_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] IDLE    = 2'(SRC_IDLE);
  localparam logic [1:0] IC_BUSY = 2'(SRC_ICACHE);
  localparam logic [1:0] BR_BUSY = 2'(SRC_BROM);

  logic [1:0]             state_q;
  logic [1:0]             state_d;
  fetch_track_t           head;
  fetch_track_t           push_entry;
  logic [CNT_W-1:0]       count;
  logic [ADDR_WIDTH-1:0]  head_vaddr;
  logic [INSTR_WIDTH-1:0] line_word;
  logic fifo_empty, req_is_brom, tgt_rdy, not_full, src_ok, accept;
  logic ic_resp, br_resp, pop, spurious_evt, deliver;

  assign fifo_empty = (count == '0);
  assign head_vaddr = head.vaddr[ADDR_WIDTH-1:0];

  generate
    if (ADDR_WIDTH < VADDR_MAX_W) begin : g_vaddr_hi
      logic unused_vaddr_hi;
      assign unused_vaddr_hi = ^head.vaddr[VADDR_MAX_W-1:ADDR_WIDTH];
    end
  endgenerate

  assign req_is_brom = ~en_translation_i & (req_vaddr_i < ADDR_WIDTH'(BROM_SIZE)) & ~csr_spi_config_i;
  assign tgt_rdy     = req_is_brom ? brom_req_ready_i : icache_req_ready_i;

  // An exception still answers the outstanding ICache fetch.
  assign ic_resp      = icache_resp_valid_i | icache_resp_xcpt_i;
  assign br_resp      = brom_resp_valid_i;
  assign pop          = ~fifo_empty & (head.is_brom ? br_resp : ic_resp);
  assign spurious_evt = (ic_resp & (fifo_empty | head.is_brom)) |
                        (br_resp & (fifo_empty | ~head.is_brom));

  // A source switch waits for a fully drained FIFO so responses cannot reorder.
  assign not_full    = (count < CNT_W'(MAX_OUTSTANDING)) | pop;
  assign src_ok      = (state_q == IDLE) | (state_q == (req_is_brom ? BR_BUSY : IC_BUSY));
  assign req_ready_o = tgt_rdy & not_full & src_ok;
  assign accept      = req_valid_i & req_ready_o;

  assign icache_req_valid_o  = accept & ~req_is_brom;
  assign brom_req_valid_o    = accept & req_is_brom;
  assign icache_req_idx_o    = req_vaddr_i[11:0];
  assign icache_req_vpn_o    = req_vaddr_i[ADDR_WIDTH-1:12];
  assign brom_req_addr_o     = req_vaddr_i[BROM_ADDR_WIDTH-1:0];
  assign icache_req_kill_o   = req_kill_i;
  assign icache_invalidate_o = req_inval_icache_i;
  assign outstanding_o       = count;

  always_comb begin
    push_entry         = '0;
    push_entry.vaddr   = VADDR_MAX_W'(req_vaddr_i);
    push_entry.is_brom = req_is_brom;
  end

  fetch_track_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_track (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (accept),
    .push_dat_i (push_entry),
    .pop_i      (pop),
    .drop_all_i (req_kill_i),
    .head_o     (head),
    .count_o    (count)
  );

  generate
    if (WORDS > 1) begin : g_sel
      logic [SEL_W-1:0]              sel;
      logic [$clog2(LINE_WIDTH)-1:0] base;
      assign sel       = head_vaddr[OFF_LO +: SEL_W];
      assign base      = {sel, {IW_LOG{1'b0}}};
      assign line_word = icache_resp_data_i[base +: INSTR_WIDTH];
    end else begin : g_nosel
      assign line_word = icache_resp_data_i[INSTR_WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    if (accept) state_d = req_is_brom ? BR_BUSY : IC_BUSY;
    else if (pop && count == CNT_W'(1)) state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A kill in the response cycle suppresses that response as well.
  assign deliver = pop & ~head.drop & ~req_kill_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_valid_o      <= 1'b0;
      resp_data_o       <= '0;
      resp_vaddr_o      <= '0;
      resp_page_fault_o <= 1'b0;
      spurious_resp_o   <= 1'b0;
    end else begin
      resp_valid_o <= deliver;
      if (deliver) begin
        resp_vaddr_o      <= head_vaddr;
        resp_page_fault_o <= ~head.is_brom & icache_resp_xcpt_i;
        if (head.is_brom)            resp_data_o <= brom_resp_data_i;
        else if (icache_resp_xcpt_i) resp_data_o <= '0;
        else                         resp_data_o <= line_word;
      end
      if (spurious_evt) spurious_resp_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_fetch_interface.sv
// Scoreboard bench: a queue model of in-flight fetches predicts ready/steering/occupancy
// and pushes expected responses that a separate monitor matches against resp_*.
module tb_icache_fetch_interface;

  localparam int MAXO = 2;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic         rst_i;
  logic         req_valid_i;
  logic [39:0]  req_vaddr_i;
  logic         req_kill_i;
  logic         req_inval_icache_i;
  logic         en_translation_i;
  logic         csr_spi_config_i;
  logic         req_ready_o;
  logic         icache_req_valid_o;
  logic         icache_req_ready_i;
  logic [11:0]  icache_req_idx_o;
  logic [27:0]  icache_req_vpn_o;
  logic         icache_req_kill_o;
  logic         icache_invalidate_o;
  logic         icache_resp_valid_i;
  logic [127:0] icache_resp_data_i;
  logic         icache_resp_xcpt_i;
  logic         brom_req_valid_o;
  logic         brom_req_ready_i;
  logic [23:0]  brom_req_addr_o;
  logic         brom_resp_valid_i;
  logic [31:0]  brom_resp_data_i;
  logic         resp_valid_o;
  logic [31:0]  resp_data_o;
  logic [39:0]  resp_vaddr_o;
  logic         resp_page_fault_o;
  logic [1:0]   outstanding_o;
  logic         spurious_resp_o;

  icache_fetch_interface #(
    .ADDR_WIDTH(40), .LINE_WIDTH(128), .INSTR_WIDTH(32),
    .MAX_OUTSTANDING(MAXO), .BROM_SIZE('h100), .BROM_ADDR_WIDTH(24)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_vaddr_i(req_vaddr_i), .req_kill_i(req_kill_i),
    .req_inval_icache_i(req_inval_icache_i), .en_translation_i(en_translation_i),
    .csr_spi_config_i(csr_spi_config_i), .req_ready_o(req_ready_o),
    .icache_req_valid_o(icache_req_valid_o), .icache_req_ready_i(icache_req_ready_i),
    .icache_req_idx_o(icache_req_idx_o), .icache_req_vpn_o(icache_req_vpn_o),
    .icache_req_kill_o(icache_req_kill_o), .icache_invalidate_o(icache_invalidate_o),
    .icache_resp_valid_i(icache_resp_valid_i), .icache_resp_data_i(icache_resp_data_i),
    .icache_resp_xcpt_i(icache_resp_xcpt_i),
    .brom_req_valid_o(brom_req_valid_o), .brom_req_ready_i(brom_req_ready_i),
    .brom_req_addr_o(brom_req_addr_o), .brom_resp_valid_i(brom_resp_valid_i),
    .brom_resp_data_i(brom_resp_data_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_vaddr_o(resp_vaddr_o),
    .resp_page_fault_o(resp_page_fault_o), .outstanding_o(outstanding_o),
    .spurious_resp_o(spurious_resp_o)
  );

  typedef struct { logic [39:0] va; bit brom; bit drop; } ent_t;
  typedef struct { int due; logic [31:0] data; logic [39:0] va; logic pf; } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  bit   exp_spur;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a response is due exactly one cycle after the memory answered.
  always @(negedge clk_i) begin
    if (resp_valid_o === 1'b1) begin
      if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
        chk("unexpected_resp", 64'(resp_valid_o), 64'd0);
      end else begin
        chk("resp_data",  64'(resp_data_o),       64'(exp_q[0].data));
        chk("resp_vaddr", 64'(resp_vaddr_o),      64'(exp_q[0].va));
        chk("resp_pf",    64'(resp_page_fault_o), 64'(exp_q[0].pf));
        exp_q.delete(0);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      chk("missing_resp", 64'(resp_valid_o), 64'd1);
      exp_q.delete(0);
    end
  end

  task automatic cycle(input logic rv, input logic [39:0] va, input logic kill,
                       input logic icr, input logic brr, input logic icv, input logic icx,
                       input logic [127:0] line, input logic brv, input logic [31:0] bd,
                       input logic tr, input logic spi, input logic inval);
    bit tgt_brom, h, resp_head, spur, tgt_rdy, exp_rdy, acc;
    ent_t e;
    exp_t x;
    logic [127:0] w;
    rst_i = 1'b0;
    req_valid_i = rv; req_vaddr_i = va; req_kill_i = kill; req_inval_icache_i = inval;
    en_translation_i = tr; csr_spi_config_i = spi;
    icache_req_ready_i = icr; brom_req_ready_i = brr;
    icache_resp_valid_i = icv; icache_resp_xcpt_i = icx; icache_resp_data_i = line;
    brom_resp_valid_i = brv; brom_resp_data_i = bd;
    @(negedge clk_i);
    chk("outstanding", 64'(outstanding_o), 64'(mq.size()));
    chk("spurious", 64'(spurious_resp_o), 64'(exp_spur));
    tgt_brom  = !tr && (va < 40'h100) && !spi;
    h         = mq.size() > 0;
    resp_head = h && (mq[0].brom ? brv : (icv || icx));
    spur      = ((icv || icx) && (!h || mq[0].brom)) || (brv && (!h || !mq[0].brom));
    tgt_rdy   = tgt_brom ? brr : icr;
    exp_rdy   = tgt_rdy && ((mq.size() - int'(resp_head)) < MAXO) && (!h || mq[0].brom == tgt_brom);
    acc       = rv && exp_rdy;
    chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
    chk("ic_req_valid", 64'(icache_req_valid_o), 64'(acc && !tgt_brom));
    chk("brom_req_valid", 64'(brom_req_valid_o), 64'(acc && tgt_brom));
    chk("kill_pass", 64'(icache_req_kill_o), 64'(kill));
    chk("inval_pass", 64'(icache_invalidate_o), 64'(inval));
    if (acc && tgt_brom) chk("brom_addr", 64'(brom_req_addr_o), 64'(va[23:0]));
    if (acc && !tgt_brom) begin
      chk("ic_idx", 64'(icache_req_idx_o), 64'(va[11:0]));
      chk("ic_vpn", 64'(icache_req_vpn_o), 64'(va[39:12]));
    end
    if (resp_head) begin
      e = mq.pop_front();
      if (!e.drop && !kill) begin
        x.due = cyc + 1;
        x.va  = e.va;
        x.pf  = 1'b0;
        if (e.brom) x.data = bd;
        else if (icx) begin x.data = '0; x.pf = 1'b1; end
        else begin w = line >> (32 * int'(e.va[3:2])); x.data = w[31:0]; end
        exp_q.push_back(x);
      end
    end
    if (spur) exp_spur = 1'b1;
    if (kill) foreach (mq[i]) mq[i].drop = 1'b1;
    if (acc) mq.push_back('{va: va, brom: tgt_brom, drop: 1'b0});
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    cycle(0, '0, 0, 1, 1, 0, 0, '0, 0, '0, 0, 0, 0);
  endtask

  task automatic icreq(input logic [39:0] va);
    cycle(1, va, 0, 1, 1, 0, 0, '0, 0, '0, 0, 0, 0);
  endtask

  task automatic icresp(input logic [127:0] line);
    cycle(0, '0, 0, 1, 1, 1, 0, line, 0, '0, 0, 0, 0);
  endtask

  task automatic do_reset();
    req_valid_i = 0; req_kill_i = 0; icache_resp_valid_i = 0; icache_resp_xcpt_i = 0;
    brom_resp_valid_i = 0;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    mq.delete();
    exp_spur = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] l1;
    rst_i = 1'b1;
    req_valid_i = 0; req_vaddr_i = '0; req_kill_i = 0; req_inval_icache_i = 0;
    en_translation_i = 0; csr_spi_config_i = 0; icache_req_ready_i = 1; brom_req_ready_i = 1;
    icache_resp_valid_i = 0; icache_resp_data_i = '0; icache_resp_xcpt_i = 0;
    brom_resp_valid_i = 0; brom_resp_data_i = '0;
    exp_spur = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rst_resp_data", 64'(resp_data_o), 64'd0);
    chk("rst_resp_vaddr", 64'(resp_vaddr_o), 64'd0);
    chk("rst_resp_pf", 64'(resp_page_fault_o), 64'd0);
    chk("rst_outstanding", 64'(outstanding_o), 64'd0);
    chk("rst_spurious", 64'(spurious_resp_o), 64'd0);

    // Word select from a line: index 2 of the line.
    l1 = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
    icreq(40'h8000_0008);
    icresp(l1);
    idle();

    // Depth-limited back-to-back, third stalls.
    icreq(40'h1000);
    icreq(40'h1004);
    icreq(40'h1008);
    icresp({$urandom, $urandom, $urandom, $urandom});
    icresp({$urandom, $urandom, $urandom, $urandom});
    idle();

    // Kill with two in flight, coincident response and new request.
    icreq(40'h3000);
    icreq(40'h3004);
    cycle(1, 40'h2000, 1, 1, 1, 1, 0, {$urandom, $urandom, $urandom, $urandom}, 0, '0, 0, 0, 0);
    icresp({$urandom, $urandom, $urandom, $urandom});
    icresp({$urandom, $urandom, $urandom, $urandom});
    idle();

    // Bootrom request waits for the ICache entry to drain.
    icreq(40'h5000);
    cycle(1, 40'h40, 0, 1, 1, 0, 0, '0, 0, '0, 0, 0, 0);
    cycle(1, 40'h40, 0, 1, 1, 1, 0, {$urandom, $urandom, $urandom, $urandom}, 0, '0, 0, 0, 0);
    cycle(1, 40'h40, 0, 1, 1, 0, 0, '0, 0, '0, 0, 0, 0);
    cycle(0, '0, 0, 1, 1, 0, 0, '0, 1, 32'h1357_9bdf, 0, 0, 0);
    idle();

    // Page fault.
    icreq(40'h6004);
    cycle(0, '0, 0, 1, 1, 0, 1, {$urandom, $urandom, $urandom, $urandom}, 0, '0, 0, 0, 0);
    idle();

    // Reset with one in flight, then a stale response.
    icreq(40'h7000);
    do_reset();
    icresp({$urandom, $urandom, $urandom, $urandom});
    idle();
    idle();
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      logic rv, kill, icr, brr, icv, icx, brv, tr, spi, inval;
      logic [39:0]  va;
      logic [127:0] line;
      logic [31:0]  bd;
      rv    = ($urandom % 4) != 0;
      tr    = ($urandom % 4) == 0;
      spi   = ($urandom % 6) == 0;
      if ($urandom % 2) va = {8'($urandom), 32'($urandom)};
      else              va = 40'($urandom_range(0, 'h1ff));
      icr   = ($urandom % 4) != 0;
      brr   = ($urandom % 3) != 0;
      icv = 0; icx = 0; brv = 0;
      if (mq.size() > 0 && ($urandom % 3) == 0) begin
        if (mq[0].brom) brv = 1;
        else if (($urandom % 8) == 0) icx = 1;
        else icv = 1;
      end
      line  = {$urandom, $urandom, $urandom, $urandom};
      bd    = $urandom;
      kill  = ($urandom % 25) == 0;
      inval = $urandom % 2;
      cycle(rv, va, kill, icr, brr, icv, icx, line, brv, bd, tr, spi, inval);
    end

    repeat (4) idle();
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
